jtframe_rom_arb: RTL and testbench
==================================

# jtframe_rom_arb

Multi-slot SDRAM read arbiter with one-entry-per-slot caching. It sits between the game core's ROM requesters and the frame SDRAM read port (`sdram_req`/`sdram_addr`/`sdram_ack`/`data_rdy`/`data_read`/`refresh_en`). It shares that single port among SLOTS requesters, re-serving repeated addresses from a per-slot 32-bit cache without touching SDRAM. It also tells the SDRAM controller when the bus is idle enough to refresh.

## Interface
- SLOTS, 4: number of requesters (2..8).
- AW, 22: SDRAM word-address width.
- RR, 1: 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- downloading  in  1  ROM download in progress; blocks new fetches and flushes all caches.
- slot_cs  in  SLOTS  per-slot request, level-sensitive.
- slot_addr  in  SLOTS*AW  per-slot word address; slot i occupies bits [i*AW +: AW].
- slot_clr  in  SLOTS  per-slot cache invalidate pulse.
- slot_ok  out  SLOTS  slot data valid for the current address (combinational).
- slot_dout  out  SLOTS*32  per-slot cached data; slot i occupies [i*32 +: 32].
- sdram_req  out  1  read request to the SDRAM controller.
- sdram_addr  out  AW  read address.
- sdram_ack  in  1  the controller has accepted the request.
- data_rdy  in  1  `data_read` is valid this cycle.
- data_read  in  32  SDRAM read data.
- refresh_en  out  1  arbiter idle with nothing pending; refresh permitted.

## Operation
Per-slot state:
- `valid[i]`, `tag[i]` (AW bits), `dout[i]` (32 bits).
- hit[i] = slot_cs[i] & valid[i] & (tag[i] == slot_addr[i]).
- slot_ok[i] = hit[i]. This is combinational.
- pend[i] = slot_cs[i] & ~hit[i].

Reset values:
- valid = 0, tag = 0, slot_dout = 0.
- sdram_req = 0, sdram_addr = 0, refresh_en = 0.
- state = IDLE; round-robin pointer `last` = SLOTS-1.

State machine:
- IDLE:
  - If ~downloading and |pend: pick winner w, latch `cur` = w and `cur_addr` = slot_addr[w], set sdram_req = 1 and sdram_addr = slot_addr[w], set `last` = w, go to WAIT_ACK.
  - Arbitration with RR=1: first pending index scanning last+1, last+2, … modulo SLOTS. With RR=0: lowest pending index.
- WAIT_ACK:
  - Hold sdram_req and sdram_addr stable.
  - On sdram_ack: sdram_req = 0, go to WAIT_RDY.
- WAIT_RDY:
  - On data_rdy: dout[cur] = data_read, tag[cur] = cur_addr, valid[cur] = 1 (subject to the rules below), go to IDLE.

refresh_en is registered: it is 1 when next state is IDLE and no slot is pending or downloading is high; otherwise 0.

Boundary rules:
- Requester changes its address mid-fetch: the fill still uses the latched `cur_addr`. A mismatch is then simply a miss and is re-arbitrated.
- Requester drops slot_cs mid-fetch: the fetch completes and the fill is stored.
- slot_clr[i] in the same cycle as a fill of slot i: clear wins, valid[i] = 0. The data and tag are still written.
- downloading high:
  - All valid bits clear every cycle.
  - No transition out of IDLE.
  - An in-flight transaction completes its handshake, but the fill does not set valid.
- data_rdy outside WAIT_RDY and sdram_ack outside WAIT_ACK are ignored.
- Reset mid-transaction: immediate return to reset values. The SDRAM controller is reset by the same rst_n.

## Timing
- Hit: slot_ok is asserted in the same cycle the matching slot_addr/slot_cs is presented; latency 0.
- Miss: pend seen in cycle 0; sdram_req = 1 from cycle 1.
  - sdram_ack sampled in cycle a ≥ 1: req low from a+1.
  - data_rdy sampled in cycle r ≥ a+1: slot_dout and valid updated at r+1; slot_ok = 1 in r+1 if the address is unchanged.
  - Minimum miss latency is 3 cycles (a = 1, r = 2).
- Back-to-back: a new request can issue in the cycle after the fill (IDLE lasts one cycle).
- The SDRAM controller must not assert data_rdy in the same cycle as sdram_ack for the same request.
- sdram_addr is registered and changes only on IDLE→WAIT_ACK.

## Test plan
- Reset release, slot 0 cs with addr 0x00100:
  - sdram_req rises cycle 1 with sdram_addr 0x00100.
  - ack cycle 1, data_rdy cycle 2 with 0xDEADBEEF → slot_ok[0] = 1 and slot_dout[0] = 0xDEADBEEF at cycle 3.
  - Re-present 0x00100 → slot_ok[0] = 1 immediately, no sdram_req.
- RR=1, slots 0..3 all missing simultaneously, ack and rdy immediate: grants in order 0, 1, 2, 3, then 0 again on a new miss. With RR=0 and slot 0 continuously missing, slot 3 is never granted.
- Slot 1 changes address 0x200→0x300 while in WAIT_RDY: fill stores tag 0x200, slot_ok[1] stays 0, and a second request for 0x300 follows.
- slot_clr[2] coincident with slot 2 data_rdy → valid[2] = 0 and slot_ok[2] = 0 next cycle despite the address matching.
- downloading raised during WAIT_ACK: handshake completes, no valid set, no further sdram_req while downloading = 1, refresh_en = 1. After downloading falls, pending misses resume.
- rst_n pulsed low in WAIT_RDY → sdram_req = 0, all slot_ok = 0, slot_dout = 0 asynchronously. A data_rdy arriving after release is ignored.

Source files
------------

// File: rtl/jtframe_rom_arb.sv
// SDRAM read arbiter: shares one SDRAM read port among SLOTS requesters.
// Each slot keeps a one-entry cache (tag + 32-bit word). Repeated addresses
// are served from that cache with no SDRAM traffic.
module jtframe_rom_arb #(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int RR    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  downloading,
  input  logic [SLOTS-1:0]      slot_cs,
  input  logic [SLOTS*AW-1:0]   slot_addr,
  input  logic [SLOTS-1:0]      slot_clr,
  output logic [SLOTS-1:0]      slot_ok,
  output logic [SLOTS*32-1:0]   slot_dout,
  output logic                  sdram_req,
  output logic [AW-1:0]         sdram_addr,
  input  logic                  sdram_ack,
  input  logic                  data_rdy,
  input  logic [31:0]           data_read,
  output logic                  refresh_en
);

  localparam int IW = $clog2(SLOTS);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

  state_t                    state_q;
  logic [SLOTS-1:0]          valid_q;
  logic [SLOTS-1:0][AW-1:0]  tag_q;
  logic [SLOTS-1:0][31:0]    dout_q;
  logic [IW-1:0]             last_q, cur_q;
  logic [AW-1:0]             cur_addr_q, addr_q;
  logic                      req_q, refresh_q;

  logic [SLOTS-1:0]          hit, pend;
  logic [IW-1:0]             win_d;
  logic [AW-1:0]             win_addr_d;
  logic                      found, start, fill, nxt_idle;
  int                        idx;

  // Per-slot hit/miss detection and output unpacking
  genvar g;
  generate
    for (g = 0; g < SLOTS; g++) begin : g_slot
      assign hit[g]  = slot_cs[g] & valid_q[g] & (tag_q[g] == slot_addr[g*AW +: AW]);
      assign pend[g] = slot_cs[g] & ~hit[g];
      assign slot_dout[g*32 +: 32] = dout_q[g];
    end
  endgenerate

  assign slot_ok    = hit;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign refresh_en = refresh_q;

  // Winner selection: rotate from last+1 (round robin) or scan from 0 (fixed)
  always_comb begin
    found = 1'b0;
    win_d = '0;
    idx   = 0;
    for (int k = 0; k < SLOTS; k++) begin
      idx = (RR != 0) ? (int'(last_q) + 1 + k) % SLOTS : k;
      if (!found && pend[idx]) begin
        found = 1'b1;
        win_d = IW'(idx);
      end
    end
    win_addr_d = slot_addr[int'(win_d)*AW +: AW];
  end

  assign start    = (state_q == IDLE) && !downloading && found;
  assign fill     = (state_q == WAIT_RDY) && data_rdy;
  assign nxt_idle = ((state_q == IDLE) && !start) || fill;

  // Request FSM with registered SDRAM request/address and refresh permission
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= IW'(SLOTS-1);
      cur_q      <= '0;
      cur_addr_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      refresh_q  <= 1'b0;
    end else begin
      refresh_q <= nxt_idle && (!(|pend) || downloading);
      case (state_q)
        IDLE: if (start) begin
          cur_q      <= win_d;
          cur_addr_q <= win_addr_d;
          last_q     <= win_d;
          addr_q     <= win_addr_d;
          req_q      <= 1'b1;
          state_q    <= WAIT_ACK;
        end
        WAIT_ACK: if (sdram_ack) begin
          req_q   <= 1'b0;
          state_q <= WAIT_RDY;
        end
        WAIT_RDY: if (data_rdy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Cache fill; clear and download flush take priority over setting valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      tag_q   <= '0;
      dout_q  <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (fill && cur_q == IW'(i)) begin
          tag_q[i]  <= cur_addr_q;
          dout_q[i] <= data_read;
        end
        if (downloading || slot_clr[i]) valid_q[i] <= 1'b0;
        else if (fill && cur_q == IW'(i)) valid_q[i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Directed bench for jtframe_rom_arb: one round-robin instance and one
// fixed-priority instance sharing the requester-side inputs.
module tb_jtframe_rom_arb;
  localparam int SLOTS = 4;
  localparam int AW    = 22;

  logic                clk = 0;
  logic                rst_n = 0;
  logic                downloading = 0;
  logic [SLOTS-1:0]    cs = '0, clr = '0;
  logic [SLOTS*AW-1:0] addr = '0;
  logic                ack = 0, rdy = 0, ack0 = 0, rdy0 = 0;
  logic [31:0]         data = '0, data0 = '0;
  logic [SLOTS-1:0]    ok, ok0;
  logic [SLOTS*32-1:0] dout, dout0;
  logic                req, req0, refr, refr0;
  logic [AW-1:0]       saddr, saddr0;

  int n_chk = 0, n_pass = 0;

  jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW), .RR(1)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .slot_cs(cs), .slot_addr(addr), .slot_clr(clr),
    .slot_ok(ok), .slot_dout(dout),
    .sdram_req(req), .sdram_addr(saddr), .sdram_ack(ack),
    .data_rdy(rdy), .data_read(data), .refresh_en(refr));

  jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW), .RR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .slot_cs(cs), .slot_addr(addr), .slot_clr(clr),
    .slot_ok(ok0), .slot_dout(dout0),
    .sdram_req(req0), .sdram_addr(saddr0), .sdram_ack(ack0),
    .data_rdy(rdy0), .data_read(data0), .refresh_en(refr0));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr[i*AW +: AW] = a;
  endtask

  function automatic logic [31:0] word(input int i);
    return dout[i*32 +: 32];
  endfunction

  // Serve one request on the RR instance with immediate ack and data
  task automatic xact(input string tag, input logic [AW-1:0] ea, input logic [31:0] d);
    chk({tag, "_req"}, 64'(req), 64'd1);
    chk({tag, "_addr"}, 64'(saddr), 64'(ea));
    ack = 1; step(); ack = 0;
    chk({tag, "_reqlow"}, 64'(req), 64'd0);
    rdy = 1; data = d; step(); rdy = 0;
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_req", 64'(req), 0);
    chk("rst_saddr", 64'(saddr), 0);
    chk("rst_refresh", 64'(refr), 0);
    chk("rst_dout", 64'(|dout), 0);
    rst_n = 1;
    step();
    chk("idle_refresh", 64'(refr), 1);

    // first miss, minimum latency fill, then hit
    cs = 4'b0001; set_addr(0, 22'h00100); #1;
    chk("miss_ok0", 64'(ok[0]), 0);
    step();
    chk("miss_refresh", 64'(refr), 0);
    xact("t1", 22'h00100, 32'hDEADBEEF);
    chk("fill_ok0", 64'(ok[0]), 1);
    chk("fill_dout0", 64'(word(0)), 64'hDEADBEEF);
    step();
    chk("hit_noreq", 64'(req), 0);
    chk("hit_refresh", 64'(refr), 1);
    chk("hit_ok0", 64'(ok[0]), 1);

    // round robin: all four miss, grants 0,1,2,3 then 0 again
    rst_n = 0; #1; rst_n = 1;
    cs = 4'b1111;
    for (int i = 0; i < SLOTS; i++) set_addr(i, 22'h1000 + 22'(i));
    for (int i = 0; i < SLOTS; i++) begin
      step();
      xact("rr", 22'h1000 + 22'(i), 32'hA0 + 32'(i));
    end
    chk("rr_allok", 64'(ok), 64'hF);
    chk("rr_dout3", 64'(word(3)), 64'hA3);
    set_addr(0, 22'h2000);
    step();
    xact("rr_wrap", 22'h2000, 32'hB0);
    chk("rr_wrap_ok", 64'(ok), 64'hF);

    // slot 1 changes address during WAIT_RDY
    cs = 4'b0010; set_addr(1, 22'h200);
    step();
    chk("mv_addr", 64'(saddr), 64'h200);
    ack = 1; step(); ack = 0;
    set_addr(1, 22'h300); rdy = 1; data = 32'h11112222; step(); rdy = 0;
    chk("mv_ok1", 64'(ok[1]), 0);
    chk("mv_dout1", 64'(word(1)), 64'h11112222);
    step();
    xact("mv2", 22'h300, 32'h33334444);
    chk("mv2_ok1", 64'(ok[1]), 1);

    // clear coincident with fill
    cs = 4'b0100; set_addr(2, 22'h400);
    step();
    chk("clr_addr", 64'(saddr), 64'h400);
    ack = 1; step(); ack = 0;
    rdy = 1; data = 32'h55556666; clr = 4'b0100; step(); rdy = 0; clr = '0;
    chk("clr_ok2", 64'(ok[2]), 0);
    chk("clr_dout2", 64'(word(2)), 64'h55556666);
    step();
    xact("clr_refetch", 22'h400, 32'h77778888);
    chk("clr_refetch_ok", 64'(ok[2]), 1);

    // downloading raised during WAIT_ACK
    cs = 4'b1000; set_addr(3, 22'h500);
    step();
    chk("dl_req", 64'(req), 1);
    downloading = 1; ack = 1; step(); ack = 0;
    rdy = 1; data = 32'h99990000; step(); rdy = 0;
    chk("dl_ok3", 64'(ok[3]), 0);
    chk("dl_refresh", 64'(refr), 1);
    cs = 4'b1111; step(); step(); #1;
    chk("dl_flush", 64'(ok), 0);
    chk("dl_noreq", 64'(req), 0);
    chk("dl_refresh2", 64'(refr), 1);
    downloading = 0;
    step();
    xact("dl_resume", 22'h2000, 32'hC0);
    chk("dl_resume_ok0", 64'(ok[0]), 1);

    // asynchronous reset in WAIT_RDY
    cs = 4'b0001; set_addr(0, 22'h600);
    step();
    chk("ar_req", 64'(req), 1);
    ack = 1; step(); ack = 0;
    set_addr(0, 22'h2000); cs = 4'b0111;
    rst_n = 0; #1;
    chk("ar_req0", 64'(req), 0);
    chk("ar_saddr", 64'(saddr), 0);
    chk("ar_ok", 64'(ok), 0);
    chk("ar_dout", 64'(|dout), 0);
    cs = '0; rst_n = 1; rdy = 1; data = 32'hBAD0BAD0; step(); rdy = 0;
    chk("ar_ign_dout", 64'(|dout), 0);
    chk("ar_ign_req", 64'(req), 0);

    // fixed priority: slot 0 keeps missing, slot 3 never granted
    rst_n = 0; #1; rst_n = 1;
    cs = 4'b1001; set_addr(3, 22'h700); set_addr(0, 22'h800);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fp_req", 64'(req0), 1);
      chk("fp_addr", 64'(saddr0), 64'(22'h800 + 22'(k)));
      ack0 = 1; step(); ack0 = 0;
      rdy0 = 1; data0 = 32'(k); step(); rdy0 = 0;
      set_addr(0, 22'h801 + 22'(k));
    end
    #1;
    chk("fp_ok3", 64'(ok0[3]), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
